button_conditioner: RTL and testbench



---
 rtl/button_conditioner_pkg.sv | 33 +++
 rtl/button_conditioner_channel.sv | 124 ++++++++++++
 rtl/button_conditioner.sv | 58 +++++
 tb/tb_button_conditioner.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
//   Shared constants and helpers for the button conditioner.
//   - EDGE_* : encodings of the EDGE_MODE parameter (what drives o_edge).
//   - edge_mode_legal : maps any EDGE_MODE value to a legal one.
//   - edge_select : picks the o_edge value from the rise/fall pulses.
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Unknown modes fall back to rising-edge behaviour.
  function automatic int edge_mode_legal(input int mode);
    if (mode == EDGE_FALL || mode == EDGE_BOTH) begin
      return mode;
    end
    return EDGE_RISE;
  endfunction

  function automatic logic edge_select(input int mode, input logic rise,
                                       input logic fall);
    logic sel;
    case (mode)
      EDGE_FALL: sel = fall;
      EDGE_BOTH: sel = rise | fall;
      default:   sel = rise;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// -----------------------------------------------------------------------------
// button_channel
//   One button channel: optional pin inversion, 2-FF synchroniser,
//   counter-based debouncer, registered rise/fall/edge pulses and a
//   one-shot long-press pulse.
//
//   Ports:
//     i_clk    : system clock, rising edge.
//     i_rst_n  : asynchronous active-low reset.
//     i_button : raw asynchronous button input.
//     o_level  : debounced pressed level (1 = pressed).
//     o_rise   : 1-cycle pulse when o_level goes 0 -> 1.
//     o_fall   : 1-cycle pulse when o_level goes 1 -> 0.
//     o_edge   : 1-cycle pulse selected by EDGE_MODE.
//     o_long   : 1-cycle pulse when the press has lasted LONG_CYCLES cycles.
// -----------------------------------------------------------------------------
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = EDGE_RISE,
  parameter int ACTIVE_LOW      = 0,
  parameter int LONG_CYCLES     = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_button,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_edge,
  output logic o_long
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 1);

  logic pin_in;

  logic              s1_d,     s1_q;
  logic              s2_d,     s2_q;
  logic              level_d,  level_q;
  logic [DB_W-1:0]   db_cnt_d, db_cnt_q;
  logic              rise_d,   rise_q;
  logic              fall_d,   fall_q;
  logic              edge_d,   edge_q;
  logic [HOLD_W-1:0] hold_d,   hold_q;
  logic              long_d,   long_q;

  // Normalise polarity so that "pressed" is always 1 from here on.
  assign pin_in = (ACTIVE_LOW != 0) ? ~i_button : i_button;

  always_comb begin
    s1_d     = pin_in;
    s2_d     = s1_q;

    level_d  = level_q;
    db_cnt_d = '0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any agreement (a glitch ending) restarts it from zero.
    if (s2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = s2_q;
        rise_d  = s2_q;
        fall_d  = ~s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // Hold counter follows the registered level, so it is cleared the cycle
    // after o_level falls and cannot fire on the release cycle.
    hold_d = '0;
    long_d = 1'b0;
    if (level_q) begin
      if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + 1'b1;
        long_d = (hold_q == HOLD_PRE);
      end else begin
        hold_d = hold_q;
      end
    end

    edge_d = edge_select(EDGE_MODE, rise_d, fall_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      edge_q   <= 1'b0;
      hold_q   <= '0;
      long_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      edge_q   <= edge_d;
      hold_q   <= hold_d;
      long_q   <= long_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
  assign o_edge  = edge_q;
  assign o_long  = long_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Multi-channel push-button conditioner. Each channel is synchronised,
//   debounced and turned into registered level / edge / long-press signals.
//   Channels are fully independent.
//
//   Ports:
//     i_clk    : system clock, rising edge.
//     i_rst_n  : asynchronous active-low reset.
//     i_button : [N_CH] raw asynchronous button inputs.
//     o_level  : [N_CH] debounced pressed level (1 = pressed).
//     o_rise   : [N_CH] 1-cycle pulse on debounced press.
//     o_fall   : [N_CH] 1-cycle pulse on debounced release.
//     o_edge   : [N_CH] 1-cycle pulse: rise, fall or both per EDGE_MODE.
//     o_long   : [N_CH] 1-cycle pulse when a press reaches LONG_CYCLES.
// -----------------------------------------------------------------------------
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = EDGE_RISE,
  parameter int ACTIVE_LOW      = 0,
  parameter int LONG_CYCLES     = 1000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_button,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_edge,
  output logic [N_CH-1:0] o_long
);

  // The edge mux is folded into each channel's output register so o_edge
  // stays a pure flop output; here the mode is just made legal.
  localparam int EDGE_SEL = edge_mode_legal(EDGE_MODE);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_MODE       (EDGE_SEL),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_channel (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_button (i_button[ch]),
      .o_level  (o_level[ch]),
      .o_rise   (o_rise[ch]),
      .o_fall   (o_fall[ch]),
      .o_edge   (o_edge[ch]),
      .o_long   (o_long[ch])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [1:0] btn;
  logic [1:0] btn_n;

  logic [1:0] d0_level, d0_rise, d0_fall, d0_edge, d0_long;
  logic [1:0] d1_level, d1_rise, d1_fall, d1_edge, d1_long;
  logic [1:0] d2_level, d2_rise, d2_fall, d2_edge, d2_long;
  logic [1:0] d3_level, d3_rise, d3_fall, d3_edge, d3_long;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc;
  int rise_cnt[2], rise_at[2], fall_cnt[2], fall_at[2];
  int long_cnt[2], long_at[2];
  int e0_cnt[2], e0_at[2], e1_cnt[2], e1_at[2], e2_cnt[2], e2_at[2];
  int al_cnt[2], al_at[2];
  int both_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0 (rising)
  button_conditioner #(.N_CH(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0),
                       .ACTIVE_LOW(0), .LONG_CYCLES(10)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_button(btn),
    .o_level(d0_level), .o_rise(d0_rise), .o_fall(d0_fall),
    .o_edge(d0_edge), .o_long(d0_long));

  // mode 1 (falling)
  button_conditioner #(.N_CH(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1),
                       .ACTIVE_LOW(0), .LONG_CYCLES(10)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_button(btn),
    .o_level(d1_level), .o_rise(d1_rise), .o_fall(d1_fall),
    .o_edge(d1_edge), .o_long(d1_long));

  // mode 2 (both)
  button_conditioner #(.N_CH(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2),
                       .ACTIVE_LOW(0), .LONG_CYCLES(10)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_button(btn),
    .o_level(d2_level), .o_rise(d2_rise), .o_fall(d2_fall),
    .o_edge(d2_edge), .o_long(d2_long));

  // active-low pins, idle high
  button_conditioner #(.N_CH(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0),
                       .ACTIVE_LOW(1), .LONG_CYCLES(10)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_button(btn_n),
    .o_level(d3_level), .o_rise(d3_rise), .o_fall(d3_fall),
    .o_edge(d3_edge), .o_long(d3_long));

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    cyc = 0;
    both_seen = 0;
    for (int ch = 0; ch < 2; ch++) begin
      rise_cnt[ch] = 0; rise_at[ch] = -1;
      fall_cnt[ch] = 0; fall_at[ch] = -1;
      long_cnt[ch] = 0; long_at[ch] = -1;
      e0_cnt[ch] = 0; e0_at[ch] = -1;
      e1_cnt[ch] = 0; e1_at[ch] = -1;
      e2_cnt[ch] = 0; e2_at[ch] = -1;
    end
  endtask

  // Cycle index 0 is the first edge after the stimulus was applied, i.e. the
  // edge at which s1 captures the new input.
  task automatic watch(input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      for (int ch = 0; ch < 2; ch++) begin
        if (d0_rise[ch]) begin rise_cnt[ch]++; rise_at[ch] = cyc; end
        if (d0_fall[ch]) begin fall_cnt[ch]++; fall_at[ch] = cyc; end
        if (d0_long[ch]) begin long_cnt[ch]++; long_at[ch] = cyc; end
        if (d0_edge[ch]) begin e0_cnt[ch]++; e0_at[ch] = cyc; end
        if (d1_edge[ch]) begin e1_cnt[ch]++; e1_at[ch] = cyc; end
        if (d2_edge[ch]) begin e2_cnt[ch]++; e2_at[ch] = cyc; end
        if (d3_rise[ch] | d3_fall[ch] | d3_long[ch]) begin
          al_cnt[ch]++; al_at[ch] = cyc;
        end
      end
      if (d0_rise == 2'b11) both_seen = 1;
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 2'b00;
    btn_n = 2'b11;
    al_cnt[0] = 0; al_cnt[1] = 0; al_at[0] = -1; al_at[1] = -1;
    clear_counts();

    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", {d0_level, d0_rise, d0_fall, d0_edge, d0_long}, 0);
    rst_n = 1'b1;
    watch(3);
    check_val("idle_level", d0_level, 2'b00);

    // Clean press on channel 0
    clear_counts();
    btn = 2'b01;
    watch(20);
    check_val("press_rise_cnt", rise_cnt[0], 1);
    check_val("press_rise_at", rise_at[0], 5);
    check_val("press_ch1_quiet", rise_cnt[1] + fall_cnt[1] + long_cnt[1], 0);
    check_val("press_m0_edge_at", e0_at[0], 5);
    check_val("press_m1_edge_cnt", e1_cnt[0], 0);
    check_val("press_m2_edge_at", e2_at[0], 5);
    check_val("press_long_cnt", long_cnt[0], 1);
    check_val("press_long_at", long_at[0], 15);
    check_val("press_level", d0_level, 2'b01);

    // Release of channel 0
    clear_counts();
    btn = 2'b00;
    watch(10);
    check_val("rel_fall_cnt", fall_cnt[0], 1);
    check_val("rel_fall_at", fall_at[0], 5);
    check_val("rel_m0_edge_cnt", e0_cnt[0], 0);
    check_val("rel_m1_edge_at", e1_at[0], 5);
    check_val("rel_m2_edge_cnt", e2_cnt[0], 1);
    check_val("rel_m2_edge_at", e2_at[0], 5);
    check_val("rel_no_long", long_cnt[0], 0);
    check_val("rel_level", d0_level, 2'b00);

    // Bounce rejection: 3-cycle highs never reach the 4-cycle threshold
    clear_counts();
    btn = 2'b01; watch(3);
    btn = 2'b00; watch(2);
    btn = 2'b01; watch(3);
    btn = 2'b00; watch(2);
    check_val("bounce_no_rise", rise_cnt[0], 0);
    check_val("bounce_level", d0_level, 2'b00);
    clear_counts();
    btn = 2'b01;
    watch(8);
    check_val("bounce_final_rise_cnt", rise_cnt[0], 1);
    check_val("bounce_final_rise_at", rise_at[0], 5);
    clear_counts();
    btn = 2'b00;
    watch(10);
    check_val("bounce_short_no_long", long_cnt[0], 0);
    check_val("bounce_fall_at", fall_at[0], 5);

    // Long press on channel 1, twice
    clear_counts();
    btn = 2'b10;
    watch(30);
    check_val("long1_rise_at", rise_at[1], 5);
    check_val("long1_cnt", long_cnt[1], 1);
    check_val("long1_at", long_at[1], 15);
    check_val("long1_ch0_quiet", rise_cnt[0] + long_cnt[0], 0);
    clear_counts();
    btn = 2'b00;
    watch(10);
    check_val("long1_fall_at", fall_at[1], 5);
    clear_counts();
    btn = 2'b10;
    watch(20);
    check_val("long2_cnt", long_cnt[1], 1);
    check_val("long2_at", long_at[1], 15);
    clear_counts();
    btn = 2'b00;
    watch(10);

    // Async reset while pressed with hold count 7
    clear_counts();
    btn = 2'b01;
    watch(13);
    check_val("prerst_level", d0_level, 2'b01);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_outputs",
              {d0_level, d0_rise, d0_fall, d0_edge, d0_long}, 0);
    check_val("async_rst_m2_level", d2_level, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_counts();
    watch(20);
    check_val("postrst_rise_at", rise_at[0], 5);
    check_val("postrst_long_at", long_at[0], 15);
    check_val("postrst_long_cnt", long_cnt[0], 1);
    clear_counts();
    btn = 2'b00;
    watch(10);

    // Simultaneous channels
    clear_counts();
    btn = 2'b11;
    watch(8);
    check_val("simul_both", both_seen, 1);
    check_val("simul_rise_at0", rise_at[0], 5);
    check_val("simul_rise_at1", rise_at[1], 5);
    clear_counts();
    btn = 2'b00;
    watch(10);
    check_val("simul_fall_cnt", fall_cnt[0] + fall_cnt[1], 2);

    // Channel 1 glitch while channel 0 debounces
    clear_counts();
    btn = 2'b01; watch(1);
    btn = 2'b11; watch(2);
    btn = 2'b01; watch(10);
    check_val("glitch_ch0_rise_at", rise_at[0], 5);
    check_val("glitch_ch1_no_rise", rise_cnt[1], 0);
    check_val("glitch_level", d0_level, 2'b01);
    clear_counts();
    btn = 2'b00;
    watch(10);

    // Active-low instance: idle-high pins gave nothing, a low press works
    check_val("al_idle_pulses", al_cnt[0] + al_cnt[1], 0);
    check_val("al_idle_level", d3_level, 2'b00);
    clear_counts();
    al_cnt[0] = 0; al_at[0] = -1;
    btn_n = 2'b10;
    watch(8);
    check_val("al_press_at", al_at[0], 5);
    check_val("al_press_level", d3_level, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
